// File: rtl/xor_parity_frame_pkg.sv
// Shared types and helpers for the streaming XOR parity stage.
package xor_pkg;

  typedef enum logic {
    S_ACCUM = 1'b0,
    S_EMIT  = 1'b1
  } xor_par_state_t;

  localparam int unsigned XOR_FRM_CNT_W = 8;

  // Bit-counter width able to hold 0..frame_len; never narrower than 1 bit.
  function automatic int unsigned xor_cnt_width(input int unsigned frame_len);
    return (frame_len < 1) ? 1 : $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/xor_parity_frame_ctr.sv
// Frame bit counter with a registered terminal-count flag.
// XOR_PARITY_CHECK_EN moves the terminal count out by one to cover the received parity bit.
module parity_frame_ctr
  import xor_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic tc
);

  localparam int unsigned CNT_W = xor_cnt_width(FRAME_LEN);
`ifdef XOR_PARITY_CHECK_EN
  localparam int unsigned TC_VAL = FRAME_LEN;
`else
  localparam int unsigned TC_VAL = FRAME_LEN - 1;
`endif
  localparam logic TC_AT_ZERO = (TC_VAL == 0);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;

  always_comb begin
    cnt_n = cnt;
    if (clr) begin
      cnt_n = '0;
    end else if (inc) begin
      cnt_n = cnt + CNT_W'(1);
    end
  end

  // tc is registered from the next count so it is valid in the same cycle as cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      tc  <= TC_AT_ZERO;
    end else begin
      cnt <= cnt_n;
      tc  <= (cnt_n == CNT_W'(TC_VAL));
    end
  end

endmodule

// File: rtl/xor_parity_frame.sv
// Streaming parity stage: running XOR over FRAME_LEN bits, one parity per frame over valid/ready.
// Build with XOR_PARITY_CHECK_EN to check a trailing received parity bit instead of generating one.
module xor_parity_frame
  import xor_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned ODD       = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_bit,
  output logic                     par_valid,
  input  logic                     par_ready,
  output logic                     par_bit,
  output logic [XOR_FRM_CNT_W-1:0] frm_cnt
);

  localparam logic ODD_BIT = 1'(ODD);

  xor_par_state_t           state;
  xor_par_state_t           state_n;
  logic                     acc;
  logic                     acc_n;
  logic                     res_n;
  logic [XOR_FRM_CNT_W-1:0] frm_cnt_n;
  logic                     in_ready_n;
  logic                     par_valid_n;
  logic                     in_xfer;
  logic                     par_xfer;
  logic                     tc;

  assign in_xfer  = in_valid && in_ready;
  assign par_xfer = par_valid && par_ready;

  parity_frame_ctr #(
    .FRAME_LEN(FRAME_LEN)
  ) u_ctr (
    .clk(clk),
    .rst(rst),
    .inc(in_xfer),
    .clr(par_xfer),
    .tc (tc)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_n   = state;
    acc_n     = acc;
    res_n     = par_bit;
    frm_cnt_n = frm_cnt;
    unique case (state)
      S_ACCUM: begin
        if (in_valid) begin
          acc_n = acc ^ in_bit;
          if (tc) begin
            res_n   = acc ^ in_bit ^ ODD_BIT;
            state_n = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (par_ready) begin
          acc_n     = 1'b0;
          frm_cnt_n = frm_cnt + XOR_FRM_CNT_W'(1);
          state_n   = S_ACCUM;
        end
      end
      default: state_n = S_ACCUM;
    endcase
    in_ready_n  = (state_n == S_ACCUM);
    par_valid_n = (state_n == S_EMIT);
  end

  // State and registered outputs; reset wins over any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ACCUM;
      acc       <= 1'b0;
      par_bit   <= 1'b0;
      frm_cnt   <= '0;
      in_ready  <= 1'b1;
      par_valid <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      par_bit   <= res_n;
      frm_cnt   <= frm_cnt_n;
      in_ready  <= in_ready_n;
      par_valid <= par_valid_n;
    end
  end

endmodule

// File: tb/tb_xor_parity_frame.sv
// Scoreboard bench for xor_parity_frame: even and odd instances share one stimulus stream.
module tb_xor_parity_frame;

  localparam int unsigned FL = 8;
`ifdef XOR_PARITY_CHECK_EN
  localparam int unsigned L = FL + 1;
`else
  localparam int unsigned L = FL;
`endif

  typedef struct {
    logic x;
    int   cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       par_ready = 1'b0;
  logic       in_ready_e, par_valid_e, par_bit_e;
  logic       in_ready_o, par_valid_o, par_bit_o;
  logic [7:0] frm_cnt_e, frm_cnt_o;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   pr_mode = 0;
  exp_t exp_q[$];
  logic frame_q[$];
  logic [7:0] exp_frm = '0;
  bit   was_rst = 1'b0;
  bit   hold = 1'b0;
  logic prev_e, prev_o;
  int   wait_cnt = 0;

  xor_parity_frame #(.FRAME_LEN(FL), .ODD(0)) dut_e (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_e), .in_bit(in_bit),
    .par_valid(par_valid_e), .par_ready(par_ready), .par_bit(par_bit_e), .frm_cnt(frm_cnt_e)
  );

  xor_parity_frame #(.FRAME_LEN(FL), .ODD(1)) dut_o (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o), .in_bit(in_bit),
    .par_valid(par_valid_o), .par_ready(par_ready), .par_bit(par_bit_o), .frm_cnt(frm_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: held low, held high, or random per cycle.
  always @(posedge clk) begin
    #2;
    if (pr_mode == 2) par_ready = 1'($urandom);
    else              par_ready = (pr_mode == 1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: collect accepted bits, fold the whole frame once it is complete.
  always @(negedge clk) begin
    if (rst) begin
      frame_q.delete();
    end else if (in_valid && in_ready_e) begin
      frame_q.push_back(in_bit);
      if (frame_q.size() == L) begin
        exp_t e;
        e.x = 1'b0;
        foreach (frame_q[i]) e.x = e.x ^ frame_q[i];
        e.cyc = cyc;
        exp_q.push_back(e);
        frame_q.delete();
      end
    end
  end

  // Monitor: parity is due the cycle after the frame completes and until it is taken.
  always @(negedge clk) begin
    bit due;
    due = (exp_q.size() > 0) && (exp_q[0].cyc < cyc);
    chk("par_valid_even", par_valid_e, due);
    chk("par_valid_odd", par_valid_o, due);
    chk("in_ready_even", in_ready_e, !due);
    chk("in_ready_odd", in_ready_o, !due);
    chk("frm_cnt_even", frm_cnt_e, exp_frm);
    chk("frm_cnt_odd", frm_cnt_o, exp_frm);
    if (was_rst) begin
      chk("reset_par_bit_even", par_bit_e, 0);
      chk("reset_par_bit_odd", par_bit_o, 0);
    end
    if (hold && due) begin
      chk("stall_par_bit_even", par_bit_e, prev_e);
      chk("stall_par_bit_odd", par_bit_o, prev_o);
    end
    hold = 1'b0;
    if (rst) begin
      exp_q.delete();
      exp_frm = '0;
      wait_cnt = 0;
    end else if (due) begin
      if (par_ready) begin
        chk("par_bit_even", par_bit_e, exp_q[0].x);
        chk("par_bit_odd", par_bit_o, exp_q[0].x ^ 1'b1);
        void'(exp_q.pop_front());
        exp_frm = exp_frm + 8'd1;
        wait_cnt = 0;
      end else begin
        hold = 1'b1;
        prev_e = par_bit_e;
        prev_o = par_bit_o;
        wait_cnt++;
        if (wait_cnt > 200) begin
          chk("par_ready_timeout", 0, 1);
          void'(exp_q.pop_front());
          wait_cnt = 0;
        end
      end
    end
    was_rst = rst;
  end

  task automatic send_bit(input logic b);
    int  n = 0;
    bit  done = 1'b0;
    in_valid = 1'b1;
    in_bit   = b;
    while (!done) begin
      @(negedge clk);
      done = in_ready_e && !rst;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 300) begin
        chk("in_ready_timeout", 0, 1);
        done = 1'b1;
      end
    end
  endtask

  task automatic idle(input int k);
    in_valid = 1'b0;
    for (int i = 0; i < k; i++) begin
      in_bit = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [FL-1:0] d, input logic p);
    for (int i = FL - 1; i >= 0; i--) send_bit(d[i]);
`ifdef XOR_PARITY_CHECK_EN
    send_bit(p);
`else
    if (p === 1'bx) in_bit = 1'b0;
`endif
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    pr_mode = 1;
    idle(2);

    send_frame(8'b1011_0000, 1'b1);
    idle(2);
    send_frame(8'b1011_0000, 1'b0);
    send_frame(8'b0000_0000, 1'b0);
    idle(3);

    // Back-pressure: parity held while upstream keeps offering bits.
    pr_mode = 0;
    send_frame(8'b1100_1010, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_bit = 1'($urandom);
      @(posedge clk);
      #1;
    end
    pr_mode = 1;
    send_frame(8'b0110_1110, 1'b0);
    idle(3);

    // Reset mid-frame, then a full frame.
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    pulse_rst();
    send_frame(8'b1111_1110, 1'b1);
    idle(3);

    // Reset while a parity is pending drops it.
    pr_mode = 0;
    send_frame(8'b1000_0000, 1'b0);
    idle(2);
    pulse_rst();
    pr_mode = 1;
    idle(2);

    // Randomized frames with gaps and random back-pressure; enough to wrap frm_cnt.
    pr_mode = 2;
    for (int f = 0; f < 300; f++) begin
      logic [FL-1:0] d;
      d = FL'($urandom);
      for (int i = FL - 1; i >= 0; i--) begin
        send_bit(d[i]);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
`ifdef XOR_PARITY_CHECK_EN
      send_bit(($urandom_range(0, 1) == 0) ? ^d : 1'($urandom));
`endif
    end
    pr_mode = 1;
    idle(20);
    chk("drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xor_parity_frame.md
# xor_parity_frame

Streaming parity stage that folds a serial bitstream through a running XOR and emits one parity bit per fixed-length frame. It sits directly downstream of the team's two-input XOR primitive: the same a^b operation is applied sequentially as `acc <= acc ^ in_bit`. It feeds link-level framing logic through a valid/ready handshake.

## Interface
- `FRAME_LEN`, default 8: data bits per frame, legal range 1..256.
- `ODD`, default 0: 0 selects even parity, 1 selects odd parity.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset is synchronous and active-high.
- `in_valid` input, 1 bit: `in_bit` is valid this cycle.
- `in_ready` output, 1 bit: the block can accept a bit this cycle.
- `in_bit` input, 1 bit: serial data bit.
- `par_valid` output, 1 bit: `par_bit` is valid.
- `par_ready` input, 1 bit: the consumer accepts `par_bit`.
- `par_bit` output, 1 bit: parity result, or the error flag in check mode.
- `frm_cnt` output, 8 bits: count of completed frames, wrapping.

## Operation
- A bit transfers when `in_valid && in_ready`. A parity transfers when `par_valid && par_ready`.
- States:
  - `S_ACCUM`: `in_ready`=1, `par_valid`=0. Each transfer does `acc <= acc ^ in_bit` and `cnt <= cnt+1`.
    - On the transfer with `cnt == FRAME_LEN-1`: `res <= acc ^ in_bit ^ ODD`, then go to `S_EMIT`.
  - `S_EMIT`: `in_ready`=0, `par_valid`=1, `par_bit`=`res`, held stable until `par_ready`.
    - On the parity transfer: `acc`=0, `cnt`=0, `frm_cnt` increments, then go to `S_ACCUM`.
- `cnt` width is `$clog2(FRAME_LEN+1)`, so the counter is at least 1 bit. `frm_cnt` wraps from 255 to 0.
- `in_valid` low in `S_ACCUM` means no state change; gaps inside a frame are legal.
- `in_bit` is ignored in `S_EMIT`. Back-pressure stalls upstream and no bit is lost.
- `FRAME_LEN`=1: every accepted bit produces one parity, `in_bit ^ ODD`.
- Reset mid-frame discards the partial frame and emits no parity. Reset during `S_EMIT` drops the pending parity.

## Timing
- Reset values: state=`S_ACCUM`, `acc`=0, `cnt`=0, `res`=0, `frm_cnt`=0.
  - Outputs after reset: `in_ready`=1, `par_valid`=0, `par_bit`=0, `frm_cnt`=0.
- Latency: the last data bit transfers in cycle N; `par_valid`=1 from cycle N+1.
- Minimum frame period is FRAME_LEN+1 cycles when `par_ready` is held high.
- `in_ready` and `par_valid` are decoded from state only. There are no combinational paths from `in_valid` or `par_ready` to outputs.
- `rst` has priority over every transfer in the same cycle.

## Configuration
- `XOR_PARITY_CHECK_EN` defined: check mode.
  - A frame is FRAME_LEN data bits followed by one received parity bit, FRAME_LEN+1 transfers in total.
  - On the last transfer: `res <= acc ^ in_bit ^ ODD`. 1 means a parity error, 0 means OK.
  - The `par_*` handshake and timing are unchanged; `par_bit` carries the error flag.
- Not defined: generate mode as described above. No check logic is compiled.

## Structure
- Package `xor_pkg`:
  - state enum `xor_par_state_t {S_ACCUM, S_EMIT}`;
  - constant `XOR_FRM_CNT_W` = 8;
  - function for the counter width.
- Sub-module `parity_frame_ctr`: bit counter with a terminal-count output.
  - Terminal count is FRAME_LEN-1, or FRAME_LEN under `XOR_PARITY_CHECK_EN`.
  - Ports: `clk`, `rst`, `inc`, `clr`, `tc`.

## Test plan
- Reset release, FRAME_LEN=8, ODD=0: `in_ready`=1, `par_valid`=0, `par_bit`=0, `frm_cnt`=0.
- Bits 1,0,1,1,0,0,0,0 back-to-back, `par_ready`=1: `par_valid`=1 for one cycle, the cycle after the 8th bit, with `par_bit`=1; `frm_cnt`=1.
- Same bits with ODD=1: `par_bit`=0. All-zero frame with ODD=0: `par_bit`=0.
- Hold `par_ready`=0 for 5 cycles in `S_EMIT` with `in_valid`=1:
  - `in_ready`=0, `par_bit` stable, no bits consumed;
  - after release, the next frame parity matches the software model.
- Assert `rst` after 4 of 8 bits, then send a full frame 1,1,1,1,1,1,1,0: exactly one parity with `par_bit`=1.
- `XOR_PARITY_CHECK_EN`, FRAME_LEN=8:
  - data 1,0,1,1,0,0,0,0 plus received parity 1 gives `par_bit`=0;
  - the same data plus received parity 0 gives `par_bit`=1;
  - 256 frames leave `frm_cnt` wrapped to 0.
